// File: rtl/iot_monitor_multi.sv
// iot_monitor_multi: aggregates per-channel device join/leave events into a range-checked count
// with peak tracking, sticky overflow/underflow flags and a hysteretic occupancy alarm.
module iot_monitor_multi #(
  parameter int N_CH     = 4,
  parameter int W        = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [N_CH-1:0] change,
  input  logic [N_CH-1:0] on_off,
  input  logic [W-1:0]    thr_hi,
  input  logic [W-1:0]    thr_lo,
  output logic [W-1:0]    count,
  output logic [W-1:0]    peak,
  output logic            alarm,
  output logic            ovf,
  output logic            unf
);
  // Sum width also covers narrow counts fed by many channels (up to +/-16 per cycle).
  localparam int RW = (W > 5 ? W : 5) + 2;

  typedef enum logic {IDLE, ALARM} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d, peak_q, peak_d, nxt;
  logic          ovf_q, ovf_d, unf_q, unf_d, ovf_ev, unf_ev;
  logic [4:0]    n_up, n_dn;
  logic [RW-1:0] raw;

  always_comb begin
    n_up = '0;
    n_dn = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_up = n_up + 5'(change[i] & on_off[i]);
      n_dn = n_dn + 5'(change[i] & ~on_off[i]);
    end
  end

  // Two's-complement sum: sign bit flags underflow, any set bit above W flags overflow.
  assign raw    = RW'(count_q) + RW'(n_up) - RW'(n_dn);
  assign unf_ev = raw[RW-1];
  assign ovf_ev = !raw[RW-1] && (raw[RW-2:W] != '0);
  assign nxt    = !SATURATE ? raw[W-1:0] : ovf_ev ? '1 : unf_ev ? '0 : raw[W-1:0];

  always_comb begin
    count_d = clr ? '0 : nxt;
    peak_d  = clr ? '0 : (nxt > peak_q ? nxt : peak_q);
    ovf_d   = !clr && (ovf_q || ovf_ev);
    unf_d   = !clr && (unf_q || unf_ev);
  end

  // Assert condition checked first so thr_lo >= thr_hi degenerates to a plain compare.
  always_comb begin
    state_d = clr ? IDLE : nxt >= thr_hi ? ALARM : nxt <= thr_lo ? IDLE : state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      peak_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      peak_q  <= peak_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign peak  = peak_q;
  assign alarm = (state_q == ALARM);
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

// File: tb/tb_iot_monitor_multi.sv
// tb_iot_monitor_multi: directed plus random stimulus on a saturating 8-bit and a wrapping 4-bit
// instance, compared against an integer model of the counting, flag and alarm rules.
module tb_iot_monitor_multi;
  logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [3:0] change = '0, on_off = '0;
  logic [7:0] thr_hi8, thr_lo8, cnt8, pk8;
  logic [3:0] thr_hi4, thr_lo4, cnt4, pk4;
  logic       al8, ov8, un8, al4, ov4, un4;

  int checks = 0, errors = 0;
  int mc[2], mp[2], hi[2], lo[2];
  bit mo[2], mu[2], ma[2];
  int mx[2] = '{255, 15};
  bit ms[2] = '{1'b1, 1'b0};

  iot_monitor_multi #(.N_CH(4), .W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .change(change), .on_off(on_off),
    .thr_hi(thr_hi8), .thr_lo(thr_lo8), .count(cnt8), .peak(pk8),
    .alarm(al8), .ovf(ov8), .unf(un8));

  iot_monitor_multi #(.N_CH(4), .W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .change(change), .on_off(on_off),
    .thr_hi(thr_hi4), .thr_lo(thr_lo4), .count(cnt4), .peak(pk4),
    .alarm(al4), .ovf(ov4), .unf(un4));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count8"}, 32'(cnt8), mc[0]);
    chk({tag, ".peak8"},  32'(pk8),  mp[0]);
    chk({tag, ".alarm8"}, 32'(al8),  32'(ma[0]));
    chk({tag, ".ovf8"},   32'(ov8),  32'(mo[0]));
    chk({tag, ".unf8"},   32'(un8),  32'(mu[0]));
    chk({tag, ".count4"}, 32'(cnt4), mc[1]);
    chk({tag, ".peak4"},  32'(pk4),  mp[1]);
    chk({tag, ".alarm4"}, 32'(al4),  32'(ma[1]));
    chk({tag, ".ovf4"},   32'(ov4),  32'(mo[1]));
    chk({tag, ".unf4"},   32'(un4),  32'(mu[1]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0; mp[k] = 0; mo[k] = 0; mu[k] = 0; ma[k] = 0;
    end
  endtask

  task automatic step(input logic [3:0] ch, input logic [3:0] oo, input bit c, input string tag);
    int raw, nx;
    change = ch; on_off = oo; clr = c;
    thr_hi8 = 8'(hi[0]); thr_lo8 = 8'(lo[0]);
    thr_hi4 = 4'(hi[1]); thr_lo4 = 4'(lo[1]);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        mc[k] = 0; mp[k] = 0; mo[k] = 0; mu[k] = 0; ma[k] = 0;
      end else begin
        raw = mc[k] + $countones(ch & oo) - $countones(ch & ~oo);
        if (ms[k]) nx = raw > mx[k] ? mx[k] : (raw < 0 ? 0 : raw);
        else       nx = ((raw % (mx[k] + 1)) + mx[k] + 1) % (mx[k] + 1);
        if (raw > mx[k]) mo[k] = 1;
        if (raw < 0) mu[k] = 1;
        if (nx > mp[k]) mp[k] = nx;
        if (nx >= hi[k]) ma[k] = 1;
        else if (nx <= lo[k]) ma[k] = 0;
        mc[k] = nx;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    hi = '{10, 12}; lo = '{6, 3};
    thr_hi8 = 8'd10; thr_lo8 = 8'd6; thr_hi4 = 4'd12; thr_lo4 = 4'd3;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(4'b0000, 4'b1111, 1'b0, "idle");

    step(4'b1111, 4'b1011, 1'b0, "net_plus2");
    step(4'b0110, 4'b0100, 1'b0, "net_cancel");
    step(4'b0111, 4'b0111, 1'b0, "to5");
    step(4'b0011, 4'b0011, 1'b0, "to7");
    chk("count_is_7", 32'(cnt8), 32'd7);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(4'b0001, 4'b0001, 1'b0, "ramp_up");
    for (int i = 0; i < 12; i++) step(4'b0010, 4'b0000, 1'b0, "ramp_dn");

    for (int i = 0; i < 63; i++) step(4'b1111, 4'b1111, 1'b0, "fill");
    step(4'b0011, 4'b0011, 1'b0, "to254");
    step(4'b1111, 4'b1111, 1'b0, "sat_hi");
    chk("sat_count255", 32'(cnt8), 32'd255);
    for (int i = 0; i < 63; i++) step(4'b1111, 4'b0000, 1'b0, "drain");
    step(4'b0011, 4'b0000, 1'b0, "to1");
    step(4'b1111, 4'b0000, 1'b0, "sat_lo");

    for (int i = 0; i < 3; i++) step(4'b1111, 4'b1111, 1'b0, "up12");
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b0000, 1'b0, "dn9");
    step(4'b1111, 4'b1111, 1'b1, "clr_prio");
    chk("clr_count0", 32'(cnt8), 32'd0);
    hi[0] = 0;
    step(4'b0000, 4'b0000, 1'b0, "clr_thr0");
    hi[0] = 10;
    step(4'b0000, 4'b0000, 1'b1, "clr2");

    for (int i = 0; i < 3; i++) step(4'b1111, 4'b1111, 1'b0, "w_up");
    step(4'b0011, 4'b0011, 1'b0, "w_to14");
    step(4'b0111, 4'b0111, 1'b0, "w_plus3");
    chk("wrap_count1", 32'(cnt4), 32'd1);
    step(4'b0011, 4'b0000, 1'b0, "w_minus2");
    chk("wrap_count15", 32'(cnt4), 32'd15);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hi[0] = $urandom_range(0, 255); lo[0] = $urandom_range(0, 255);
        hi[1] = $urandom_range(0, 15);  lo[1] = $urandom_range(0, 15);
      end
      step(4'($urandom), (i % 200 < 100) ? 4'($urandom | $urandom) : 4'($urandom & $urandom),
           $urandom_range(0, 63) == 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
